// File: rtl/dmem_arb_pkg.sv
// Shared state encoding and address constants for the data-memory port arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CPU_RD,
    ST_VGA_BURST,
    ST_VGA_DRAIN
  } arb_state_t;

  localparam logic [31:0] WORD_STRIDE = 32'd4;

endpackage

// File: rtl/dmem_port_arbiter_burst_addr_gen.sv
// Burst address generator: latches the burst base and walks it one word per step.
module burst_addr_gen
  import dmem_arb_pkg::*;
#(
  parameter int VGA_BURST = 8,
  parameter int BURST_W   = (VGA_BURST > 1) ? $clog2(VGA_BURST) : 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_load,
  input  logic        i_step,
  input  logic [31:0] i_base,
  output logic [31:0] o_addr,
  output logic        o_last
);

  logic [31:0]        r_base;
  logic [BURST_W-1:0] r_cnt;

  // The load cycle already issues word 0 at the raw base, so the count starts at 1.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_base <= 32'd0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_base <= i_base;
      r_cnt  <= BURST_W'(1);
    end else if (i_step) begin
      r_cnt <= r_cnt + BURST_W'(1);
    end
  end

  assign o_addr = r_base + (32'(r_cnt) * WORD_STRIDE);
  assign o_last = (r_cnt == BURST_W'(VGA_BURST - 1));

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-ported data memory between MEM-stage loads/stores and
// VGA line bursts; VGA has priority, but the CPU is owed the first grant after a burst.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int VGA_BURST = 8,
  parameter int BURST_W   = (VGA_BURST > 1) ? $clog2(VGA_BURST) : 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        vga_req,
  input  logic [31:0] vga_base,
  output logic        vga_ack,
  output logic        vga_rvalid,
  output logic [31:0] vga_rdata,
  output logic        vga_done,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  arb_state_t  r_state;
  arb_state_t  w_next_state;
  logic        r_cpu_owed;
  logic        w_owed_next;
  logic        w_load;
  logic        w_step;
  logic        w_last;
  logic [31:0] w_burst_addr;

  burst_addr_gen #(
    .VGA_BURST(VGA_BURST),
    .BURST_W  (BURST_W)
  ) u_addr_gen (
    .clock (clock),
    .reset (reset),
    .i_load(w_load),
    .i_step(w_step),
    .i_base(vga_base),
    .o_addr(w_burst_addr),
    .o_last(w_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cpu_owed <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_cpu_owed <= w_owed_next;
    end
  end

  // The CPU wins IDLE only when it is owed a grant or VGA is not asking.
  always_comb begin
    w_next_state = r_state;
    w_owed_next  = r_cpu_owed;
    w_load       = 1'b0;
    w_step       = 1'b0;
    cpu_rdata    = mem_rdata;
    cpu_stall    = 1'b0;
    vga_ack      = 1'b0;
    vga_rvalid   = 1'b0;
    vga_rdata    = 32'd0;
    vga_done     = 1'b0;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = 32'd0;
    mem_wdata    = 32'd0;

    case (r_state)
      ST_IDLE: begin
        w_owed_next = 1'b0;
        if (cpu_req && (r_cpu_owed || !vga_req)) begin
          mem_en   = 1'b1;
          mem_addr = cpu_addr;
          if (cpu_we) begin
            mem_we    = 1'b1;
            mem_wdata = cpu_wdata;
          end else begin
            cpu_stall    = 1'b1;
            w_next_state = ST_CPU_RD;
          end
        end else if (vga_req) begin
          vga_ack      = 1'b1;
          w_load       = 1'b1;
          mem_en       = 1'b1;
          mem_addr     = vga_base;
          cpu_stall    = cpu_req;
          w_next_state = (VGA_BURST == 1) ? ST_VGA_DRAIN : ST_VGA_BURST;
        end
      end

      ST_CPU_RD: begin
        w_next_state = ST_IDLE;
      end

      ST_VGA_BURST: begin
        mem_en     = 1'b1;
        mem_addr   = w_burst_addr;
        vga_rvalid = 1'b1;
        vga_rdata  = mem_rdata;
        cpu_stall  = cpu_req;
        w_step     = 1'b1;
        if (w_last) begin
          w_next_state = ST_VGA_DRAIN;
        end
      end

      ST_VGA_DRAIN: begin
        vga_rvalid   = 1'b1;
        vga_rdata    = mem_rdata;
        vga_done     = 1'b1;
        cpu_stall    = cpu_req;
        w_owed_next  = 1'b1;
        w_next_state = ST_IDLE;
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

    if (reset) begin
      w_load     = 1'b0;
      w_step     = 1'b0;
      cpu_rdata  = 32'd0;
      cpu_stall  = 1'b0;
      vga_ack    = 1'b0;
      vga_rvalid = 1'b0;
      vga_rdata  = 32'd0;
      vga_done   = 1'b0;
      mem_en     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = 32'd0;
      mem_wdata  = 32'd0;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_dmem_port_arbiter;

  localparam int N = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'd0;
  logic [31:0] cpu_wdata = 32'd0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        vga_req = 1'b0;
  logic [31:0] vga_base = 32'd0;
  logic        vga_ack;
  logic        vga_rvalid;
  logic [31:0] vga_rdata;
  logic        vga_done;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = 32'd0;

  logic [5:0]  ctrlVec;
  int          checkCount = 0;
  int          passCount = 0;

  logic [31:0] envMem [logic [31:0]];
  logic [31:0] refMem [logic [31:0]];

  dmem_port_arbiter #(.VGA_BURST(N)) dut (
    .clock     (clock),
    .reset     (reset),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .vga_req   (vga_req),
    .vga_base  (vga_base),
    .vga_ack   (vga_ack),
    .vga_rvalid(vga_rvalid),
    .vga_rdata (vga_rdata),
    .vga_done  (vga_done),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  assign ctrlVec = {mem_en, mem_we, cpu_stall, vga_ack, vga_rvalid, vga_done};

  function automatic logic [31:0] memInit(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] a);
    if (refMem.exists(a)) return refMem[a];
    return memInit(a);
  endfunction

  function automatic logic [31:0] envRead(input logic [31:0] a);
    if (envMem.exists(a)) return envMem[a];
    return memInit(a);
  endfunction

  // Synchronous single-port memory responding to the arbiter.
  always @(posedge clock) begin
    if (mem_en) begin
      if (mem_we) envMem[mem_addr] = mem_wdata;
      else mem_rdata <= envRead(mem_addr);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
  endtask

  task automatic applyStimulus(input logic rst, input logic cReq, input logic cWe,
                               input logic [31:0] cAddr, input logic [31:0] cWdata,
                               input logic vReq, input logic [31:0] vBase);
    @(posedge clock);
    #1;
    reset     = rst;
    cpu_req   = cReq;
    cpu_we    = cWe;
    cpu_addr  = cAddr;
    cpu_wdata = cWdata;
    vga_req   = vReq;
    vga_base  = vBase;
  endtask

  // Transaction-level model: tracks "cycles since VGA ack", a pending load, and the owed flag.
  int          vgaK = 0;
  bit          loadPend = 1'b0;
  bit          owed = 1'b0;
  logic [31:0] loadExp = 32'd0;
  logic [31:0] vBaseM = 32'd0;

  initial begin : compareProc
    logic [5:0]  eCtrl;
    logic [31:0] eAddr, eWdata, eCpu, eVga;
    bit          chkAddr, chkWdata, chkCpu, chkVga, cpuGo;
    forever begin
      @(negedge clock);
      eCtrl = 6'd0; eAddr = 32'd0; eWdata = 32'd0; eCpu = 32'd0; eVga = 32'd0;
      chkAddr = 1'b0; chkWdata = 1'b0; chkCpu = 1'b0; chkVga = 1'b0;
      if (reset) begin
        chkAddr = 1'b1; chkWdata = 1'b1; chkCpu = 1'b1; chkVga = 1'b1;
        vgaK = 0; loadPend = 1'b0; owed = 1'b0; vBaseM = 32'd0;
      end else if (loadPend) begin
        chkCpu = 1'b1; eCpu = loadExp; loadPend = 1'b0;
      end else if (vgaK > 0) begin
        eCtrl[1] = 1'b1;
        eCtrl[3] = cpu_req;
        chkVga = 1'b1;
        eVga = refRead(vBaseM + 32'(4 * (vgaK - 1)));
        if (vgaK < N) begin
          eCtrl[5] = 1'b1; chkAddr = 1'b1;
          eAddr = vBaseM + 32'(4 * vgaK);
          vgaK++;
        end else begin
          eCtrl[0] = 1'b1; owed = 1'b1; vgaK = 0;
        end
      end else begin
        cpuGo = cpu_req && (owed || !vga_req);
        owed = 1'b0;
        if (cpuGo) begin
          eCtrl[5] = 1'b1; chkAddr = 1'b1; eAddr = cpu_addr;
          if (cpu_we) begin
            eCtrl[4] = 1'b1; chkWdata = 1'b1; eWdata = cpu_wdata;
            refMem[cpu_addr] = cpu_wdata;
          end else begin
            eCtrl[3] = 1'b1; loadPend = 1'b1; loadExp = refRead(cpu_addr);
          end
        end else if (vga_req) begin
          eCtrl[5] = 1'b1; eCtrl[2] = 1'b1; eCtrl[3] = cpu_req;
          chkAddr = 1'b1; eAddr = vga_base;
          vBaseM = vga_base; vgaK = 1;
        end
      end
      checkOutput("model_ctrl", 32'(ctrlVec), 32'(eCtrl));
      if (chkAddr)  checkOutput("model_mem_addr", mem_addr, eAddr);
      if (chkWdata) checkOutput("model_mem_wdata", mem_wdata, eWdata);
      if (chkCpu)   checkOutput("model_cpu_rdata", cpu_rdata, eCpu);
      if (chkVga)   checkOutput("model_vga_rdata", vga_rdata, eVga);
    end
  end

  initial begin : mainProc
    int          enCount, rvCount, doneAt, stallCount;
    logic [31:0] burstAddr [4];
    logic [31:0] expAddr [4];
    logic        hold, rst, cReq, cWe, vReq;
    logic [31:0] cAddr, cWdata, vBase;

    expAddr[0] = 32'hFFFF_FFF8; expAddr[1] = 32'hFFFF_FFFC;
    expAddr[2] = 32'h0000_0000; expAddr[3] = 32'h0000_0004;
    envMem[32'h44] = 32'h1234_5678;
    refMem[32'h44] = 32'h1234_5678;

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
      @(negedge clock);
      checkOutput("reset_ctrl", 32'(ctrlVec), 32'd0);
      checkOutput("reset_cpu_rdata", cpu_rdata, 32'd0);
    end

    // Store: single cycle, no stall.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h40, 32'hDEAD_BEEF, 1'b0, 32'd0);
    @(negedge clock);
    checkOutput("store_ctrl", 32'(ctrlVec), 32'b110000);
    checkOutput("store_addr", mem_addr, 32'h40);
    checkOutput("store_wdata", mem_wdata, 32'hDEAD_BEEF);

    // Load: one stall cycle, then data.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h44, 32'd0, 1'b0, 32'd0);
    @(negedge clock);
    enCount = int'(mem_en);
    checkOutput("load_issue_ctrl", 32'(ctrlVec), 32'b101000);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h44, 32'd0, 1'b0, 32'd0);
    @(negedge clock);
    enCount += int'(mem_en);
    checkOutput("load_done_stall", 32'(cpu_stall), 32'd0);
    checkOutput("load_rdata", cpu_rdata, 32'h1234_5678);
    checkOutput("load_mem_en_count", 32'(enCount), 32'd1);

    // VGA burst across the address wrap.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFF8);
    @(negedge clock);
    checkOutput("burst_ack", 32'(vga_ack), 32'd1);
    burstAddr[0] = mem_addr;
    rvCount = 0; doneAt = 0;
    for (int c = 1; c <= N; c++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
      @(negedge clock);
      if (mem_en && c < N) burstAddr[c] = mem_addr;
      rvCount += int'(vga_rvalid);
      if (vga_done && vga_rvalid) doneAt = c;
    end
    for (int k = 0; k < N; k++) checkOutput("burst_addr_seq", burstAddr[k], expAddr[k]);
    checkOutput("burst_rvalid_count", 32'(rvCount), 32'd4);
    checkOutput("burst_done_cycle", 32'(doneAt), 32'd4);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);

    // Contention: VGA wins, then the owed CPU load beats the held VGA request.
    stallCount = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b0, c < 7, 1'b0, 32'h80, 32'd0, 1'b1, 32'h1000);
      @(negedge clock);
      if (c < 5) stallCount += int'(cpu_stall);
      if (c == 0) checkOutput("contend_ack_first", 32'(ctrlVec), 32'b101100);
      if (c == 5) checkOutput("contend_owed_grant", 32'(ctrlVec), 32'b101000);
      if (c == 6) checkOutput("contend_load_rdata", cpu_rdata, 32'hC325_5A3C);
      if (c == 7) checkOutput("contend_second_ack", 32'(ctrlVec), 32'b100100);
    end
    checkOutput("contend_stall_count", 32'(stallCount), 32'd5);
    for (int c = 0; c < N + 1; c++)
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);

    // Reset during the second burst word abandons the burst.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h2000);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    @(negedge clock);
    checkOutput("abort_second_addr", mem_addr, 32'h2004);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    @(negedge clock);
    checkOutput("abort_reset_ctrl", 32'(ctrlVec), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h3000);
    @(negedge clock);
    checkOutput("abort_restart_ctrl", 32'(ctrlVec), 32'b100100);
    checkOutput("abort_restart_addr", mem_addr, 32'h3000);
    for (int c = 0; c < N + 1; c++)
      applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);

    // Randomized traffic; a stalled pipeline holds its request.
    cReq = 1'b0; cWe = 1'b0; cAddr = 32'd0; cWdata = 32'd0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      hold = cpu_stall;
      rst = ($urandom_range(0, 199) == 0);
      if (!hold || rst) begin
        cReq   = ($urandom_range(0, 9) < 6);
        cWe    = $urandom_range(0, 1) == 1;
        cAddr  = {24'd0, 6'($urandom), 2'b00};
        cWdata = $urandom;
      end
      vReq = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 3) == 0) vBase = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
      else vBase = {24'd0, 6'($urandom), 2'b00};
      applyStimulus(rst, cReq, cWe, cAddr, cWdata, vReq, vBase);
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    @(negedge clock);
    #1;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single-ported data memory between the pipeline's MEM stage and the VGA line fetcher. It sequences CPU loads and stores, and issues fixed-length VGA read bursts. It drives `cpu_stall`, which freezes PC, IF/ID, ID/EX and EX/MEM whenever the MEM-stage access cannot complete this cycle. VGA has priority for display timing, with a one-grant starvation guard for the CPU.

## Interface
Parameters:
- `VGA_BURST`, 8: words per VGA burst, ≥1.
- `BURST_W`, `$clog2(VGA_BURST)` (min 1): burst counter width.

Ports:
- `clock`, in, 1: clock.
- `reset`, in, 1: reset, synchronous, active-high.
- `cpu_req`, in, 1: MEM stage holds a load or store.
- `cpu_we`, in, 1: 1 = store, 0 = load.
- `cpu_addr`, in, 32: byte address from the EX/MEM ALU result.
- `cpu_wdata`, in, 32: store data.
- `cpu_rdata`, out, 32: load data; valid when `cpu_stall`=0 in CPU_RD.
- `cpu_stall`, out, 1: freeze the upstream pipeline registers.
- `vga_req`, in, 1: level request for a line burst.
- `vga_base`, in, 32: burst start byte address.
- `vga_ack`, out, 1: one-cycle pulse; burst accepted, `vga_base` latched.
- `vga_rvalid`, out, 1: `vga_rdata` valid this cycle.
- `vga_rdata`, out, 32: burst word.
- `vga_done`, out, 1: one-cycle pulse with the last `vga_rvalid`.
- `mem_en`, out, 1: memory access strobe.
- `mem_we`, out, 1: memory write enable.
- `mem_addr`, out, 32: memory byte address.
- `mem_wdata`, out, 32: memory write data.
- `mem_rdata`, in, 32: synchronous read data, valid one cycle after `mem_en` with `mem_we`=0.

## Operation
- States: IDLE, CPU_RD, VGA_BURST, VGA_DRAIN.
- Registers: state, `base_q`, `cnt` (`BURST_W` bits), `cpu_owed`.

IDLE priority, highest first:
- `cpu_req` & `cpu_owed`: serve the CPU; clear `cpu_owed`.
- `vga_req`:
  - pulse `vga_ack`; set `base_q`=`vga_base`.
  - issue a read at `vga_base`; set `cnt`=1.
  - go to VGA_BURST, or to VGA_DRAIN if `VGA_BURST`=1.
  - `cpu_stall`=`cpu_req`.
- `cpu_req` & `cpu_we`: `mem_en`=`mem_we`=1, address/data from CPU, `cpu_stall`=0; stay in IDLE.
- `cpu_req` & !`cpu_we`: issue a read, `cpu_stall`=1, go to CPU_RD.
- `cpu_owed` clears whenever the CPU is granted, or when IDLE sees `cpu_req`=0.

Other states:
- CPU_RD:
  - no memory access; `cpu_rdata`=`mem_rdata`, `cpu_stall`=0.
  - the `cpu_req` seen here belongs to the completing load and is not reissued.
  - go to IDLE.
- VGA_BURST:
  - issue a read at `base_q` + 4·`cnt` (mod 2^32); `vga_rvalid`=1 with the previous word.
  - `cnt`++; after issuing `cnt`=`VGA_BURST`−1, go to VGA_DRAIN.
  - `cpu_stall`=`cpu_req`.
- VGA_DRAIN:
  - `vga_rvalid`=`vga_done`=1; no access; `cpu_stall`=`cpu_req`.
  - set `cpu_owed`; go to IDLE.

General rules:
- `vga_req` is ignored outside IDLE; a held request re-arbitrates in IDLE.
- Outputs are combinational from state and inputs, and forced inactive while `reset`=1.
- `cpu_rdata` outside CPU_RD equals `mem_rdata` (don't-care).
- Reset mid-burst or mid-load: return to IDLE and clear `cnt`, `base_q` and `cpu_owed`. No `vga_done`; the partial burst is abandoned.

## Timing
- Reset values: state IDLE, `cnt`=0, `base_q`=0, `cpu_owed`=0. All outputs are 0.
- Store: 1 cycle, no stall.
- Load: 2 cycles, 1 stall cycle.
- VGA burst:
  - `VGA_BURST`+1 cycles from `vga_ack` to `vga_done`.
  - `vga_rvalid` on cycles 1..`VGA_BURST` after the ack.
- Worst CPU wait: `VGA_BURST`+1 stall cycles, then guaranteed grant.
- A CPU access and a VGA issue never occur in the same cycle.

## Structure
- `dmem_arb_pkg`: state enum (IDLE, CPU_RD, VGA_BURST, VGA_DRAIN) and the word stride constant 4.
- Sub-module `burst_addr_gen`: holds `base_q` and `cnt`; inputs load/step; outputs address and last.

## Test plan
- Reset, idle 3 cycles:
  - all outputs 0, state IDLE.
- Store `cpu_addr`=0x40, `cpu_wdata`=0xDEADBEEF:
  - one cycle with `mem_en`=`mem_we`=1, `mem_addr`=0x40.
  - `cpu_stall`=0 throughout.
- Load 0x44, memory returns 0x12345678:
  - `cpu_stall`=1 for one cycle.
  - next cycle `cpu_rdata`=0x12345678, `cpu_stall`=0.
  - exactly one `mem_en`.
- `VGA_BURST`=4, `vga_base`=0xFFFFFFF8:
  - `mem_addr` sequence 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
  - 4 `vga_rvalid`, `vga_done` with the 4th.
- `vga_req` and `cpu_req` (load) together, `vga_req` held high:
  - VGA burst wins; `cpu_stall`=1 for 5 cycles.
  - the CPU load is then granted before the second VGA burst (owed).
- Reset asserted during the 2nd burst word:
  - next cycle IDLE, no `vga_done`.
  - the following `vga_req` restarts at the new `vga_base`.
